// File: rtl/motor_mix_sequencer.sv
// Time-multiplexed quad motor mixer: one shared adder walks the 16 motor/axis
// terms of a snapshot and publishes all four saturated results at once.
module motor_mix_sequencer #(
  parameter int DELTA_SHIFT = 2,
  parameter int OUT_MAX     = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] throttle_offset,
  input  logic [7:0] pitch_offset,
  input  logic [7:0] roll_offset,
  input  logic [7:0] yaw_offset,
  output logic [7:0] motor_1_offset,
  output logic [7:0] motor_2_offset,
  output logic [7:0] motor_3_offset,
  output logic [7:0] motor_4_offset,
  output logic       busy,
  output logic       done
);

  // Handshake: start is a level sampled on every edge. While busy it is
  // remembered as a single pending request, launched on the next idle edge.
  // done is a one-cycle strobe marking the cycle the four outputs change.

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ACC  = 1'b1;

  localparam logic signed [10:0] OUT_MAX_S = 11'(OUT_MAX);
  localparam logic [7:0]         OUT_MAX_U = 8'(OUT_MAX);

  logic              state_q, state_d;
  logic              pending_q, pending_d;
  logic [3:0]        step_q, step_d;
  logic [7:0]        thr_q, thr_d;
  logic [7:0]        pit_q, pit_d;
  logic [7:0]        rol_q, rol_d;
  logic [7:0]        yaw_q, yaw_d;
  logic signed [10:0] acc_q, acc_d;
  logic [7:0]        sh0_q, sh0_d;
  logic [7:0]        sh1_q, sh1_d;
  logic [7:0]        sh2_q, sh2_d;
  logic [7:0]        m1_q, m1_d;
  logic [7:0]        m2_q, m2_d;
  logic [7:0]        m3_q, m3_d;
  logic [7:0]        m4_q, m4_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0]         axis_sel;
  logic signed [8:0]  centred;
  logic signed [8:0]  shifted;
  logic signed [10:0] delta_ext;
  logic               neg_term;
  logic signed [10:0] term;
  logic signed [10:0] sum;
  logic [7:0]         sat_val;
  logic [1:0]         step_m;
  logic [1:0]         step_t;

  always_comb begin
    step_m = step_q[3:2];
    step_t = step_q[1:0];

    case (step_t)
      2'd1:    axis_sel = pit_q;
      2'd2:    axis_sel = rol_q;
      default: axis_sel = yaw_q;
    endcase

    centred   = $signed({1'b0, axis_sel}) - 9'sd128;
    shifted   = centred >>> DELTA_SHIFT;
    delta_ext = {{2{shifted[8]}}, shifted};

    // Sign pattern per motor for (pitch, roll, yaw); 1 means subtract.
    neg_term = 1'b0;
    case (step_m)
      2'd0: neg_term = (step_t == 2'd3);
      2'd1: neg_term = (step_t == 2'd2);
      2'd2: neg_term = 1'b1;
      2'd3: neg_term = (step_t == 2'd1);
      default: neg_term = 1'b0;
    endcase

    term = neg_term ? -delta_ext : delta_ext;
    sum  = acc_q + term;

    if (sum < 0)
      sat_val = 8'd0;
    else if (sum > OUT_MAX_S)
      sat_val = OUT_MAX_U;
    else
      sat_val = sum[7:0];
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    step_d    = step_q;
    thr_d     = thr_q;
    pit_d     = pit_q;
    rol_d     = rol_q;
    yaw_d     = yaw_q;
    acc_d     = acc_q;
    sh0_d     = sh0_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    m3_d      = m3_q;
    m4_d      = m4_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start || pending_q) begin
          thr_d     = throttle_offset;
          pit_d     = pitch_offset;
          rol_d     = roll_offset;
          yaw_d     = yaw_offset;
          pending_d = 1'b0;
          step_d    = 4'd0;
          busy_d    = 1'b1;
          state_d   = ST_ACC;
        end
      end
      ST_ACC: begin
        if (start)
          pending_d = 1'b1;
        if (step_t == 2'd0)
          acc_d = {3'b000, thr_q};
        else
          acc_d = sum;
        if (step_t == 2'd3) begin
          case (step_m)
            2'd0: sh0_d = sat_val;
            2'd1: sh1_d = sat_val;
            2'd2: sh2_d = sat_val;
            default: begin
              // Last motor bypasses its shadow so all four land on this edge.
              m1_d    = sh0_q;
              m2_d    = sh1_q;
              m3_d    = sh2_q;
              m4_d    = sat_val;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          endcase
        end
        step_d = step_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      step_q    <= 4'd0;
      thr_q     <= 8'd0;
      pit_q     <= 8'd0;
      rol_q     <= 8'd0;
      yaw_q     <= 8'd0;
      acc_q     <= 11'sd0;
      sh0_q     <= 8'd0;
      sh1_q     <= 8'd0;
      sh2_q     <= 8'd0;
      m1_q      <= 8'd0;
      m2_q      <= 8'd0;
      m3_q      <= 8'd0;
      m4_q      <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      step_q    <= step_d;
      thr_q     <= thr_d;
      pit_q     <= pit_d;
      rol_q     <= rol_d;
      yaw_q     <= yaw_d;
      acc_q     <= acc_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      sh2_q     <= sh2_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      m3_q      <= m3_d;
      m4_q      <= m4_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign motor_1_offset = m1_q;
  assign motor_2_offset = m2_q;
  assign motor_3_offset = m3_q;
  assign motor_4_offset = m4_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
